// File: rtl/gate_enable_ctrl.sv
// Clock-gate enable controller for the egg-timer datapath.
// Each channel owns one clock-gate enable and answers a level req with ack
// once its gated clock has had time to settle. At most MAX_ACTIVE enables
// are high at once. Free slots go to waiting channels round-robin, one new
// grant per edge. After req drops, the gate stays enabled for IDLE_HOLD
// cycles so a quick re-request resumes without a wake delay.
//
// Handshake: req is a level. A channel sees ack only while it is in ON.
// It may drop req at any time, including before ack. ack falls on the edge
// after req is sampled low. All outputs are registered.
module gate_enable_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int MAX_ACTIVE  = 2,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_HOLD   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           req,
    output logic [NUM_CH-1:0]           ack,
    output logic [NUM_CH-1:0]           gate_en,
    output logic [$clog2(NUM_CH+1)-1:0] active_cnt
);

    localparam int CNT_MAX = (WAKE_CYCLES > IDLE_HOLD) ? WAKE_CYCLES : IDLE_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NUM_CH);
    localparam int AW      = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } ch_state_t;

    // Per-channel state, readable hierarchically as state[i].
    ch_state_t     state [NUM_CH];
    logic [CW-1:0] cnt   [NUM_CH];
    logic [PW-1:0] ptr;

    logic [NUM_CH-1:0] leaving;
    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     ptr_nxt;
    logic [AW-1:0]     active_nxt;
    int                remaining;
    int                idx;

    // Arbitration: count slots still in use after this edge, then pick the
    // first requesting OFF channel at or above the pointer, with wrap-around.
    always_comb begin
        leaving     = '0;
        remaining   = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        ptr_nxt     = ptr;
        idx         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (state[i])
                S_HOLD:       leaving[i] = !req[i] && (cnt[i] == CW'(1));
                S_ON, S_WAKE: leaving[i] = !req[i] && (IDLE_HOLD == 0);
                default:      leaving[i] = 1'b0;
            endcase
            if (state[i] != S_OFF && !leaving[i]) begin
                remaining = remaining + 1;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if ((remaining < MAX_ACTIVE) && !grant_found &&
                (state[idx] == S_OFF) && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
                ptr_nxt     = (idx + 1 == NUM_CH) ? '0 : PW'(idx + 1);
            end
        end
        active_nxt = AW'(remaining + (grant_found ? 1 : 0));
    end

    // Channel FSMs with registered gate_en/ack, pointer and active count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= S_OFF;
                cnt[i]   <= '0;
            end
            ptr        <= '0;
            ack        <= '0;
            gate_en    <= '0;
            active_cnt <= '0;
        end else begin
            ptr        <= ptr_nxt;
            active_cnt <= active_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                case (state[i])
                    S_OFF: begin
                        if (grant_found && (grant_idx == PW'(i))) begin
                            state[i]   <= S_WAKE;
                            cnt[i]     <= CW'(WAKE_CYCLES);
                            gate_en[i] <= 1'b1;
                            ack[i]     <= 1'b0;
                        end
                    end
                    S_WAKE: begin
                        if (!req[i]) begin
                            ack[i] <= 1'b0;
                            if (IDLE_HOLD == 0) begin
                                state[i]   <= S_OFF;
                                cnt[i]     <= '0;
                                gate_en[i] <= 1'b0;
                            end else begin
                                state[i] <= S_HOLD;
                                cnt[i]   <= CW'(IDLE_HOLD);
                            end
                        end else if (cnt[i] == CW'(1)) begin
                            state[i] <= S_ON;
                            cnt[i]   <= '0;
                            ack[i]   <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] - CW'(1);
                        end
                    end
                    S_ON: begin
                        if (!req[i]) begin
                            ack[i] <= 1'b0;
                            if (IDLE_HOLD == 0) begin
                                state[i]   <= S_OFF;
                                cnt[i]     <= '0;
                                gate_en[i] <= 1'b0;
                            end else begin
                                state[i] <= S_HOLD;
                                cnt[i]   <= CW'(IDLE_HOLD);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (req[i]) begin
                            // Clock never stopped, so no settling is needed.
                            state[i] <= S_ON;
                            cnt[i]   <= '0;
                            ack[i]   <= 1'b1;
                        end else if (cnt[i] == CW'(1)) begin
                            state[i]   <= S_OFF;
                            cnt[i]     <= '0;
                            gate_en[i] <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] - CW'(1);
                        end
                    end
                    default: begin
                        state[i] <= S_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_enable_ctrl.sv
// Bench for gate_enable_ctrl. Two instances: defaults (A) and a single-slot,
// zero-hold variant (B). A timestamp-based model predicts every output after
// every edge. Directed scenarios pin the model with literal values.
module tb_gate_enable_ctrl;

    localparam int NCH    = 4;
    localparam int WAKE   = 2;
    localparam int MAXA_A = 2;
    localparam int IDLE_A = 4;
    localparam int MAXA_B = 1;
    localparam int IDLE_B = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] ack_a, ack_b, gate_a, gate_b;
    logic [2:0] cnt_a, cnt_b;

    int checks;
    int failures;
    int ecount;
    bit cmp_en;

    // Model state per unit/channel: enabled, acked, grant edge, drop edge.
    int m_en  [2][4];
    int m_ack [2][4];
    int m_gt  [2][4];
    int m_dt  [2][4];
    int m_ptr [2];

    logic [1:0] exp_q[$];

    gate_enable_ctrl #(.NUM_CH(NCH), .MAX_ACTIVE(MAXA_A), .WAKE_CYCLES(WAKE), .IDLE_HOLD(IDLE_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a), .gate_en(gate_a), .active_cnt(cnt_a)
    );

    gate_enable_ctrl #(.NUM_CH(NCH), .MAX_ACTIVE(MAXA_B), .WAKE_CYCLES(WAKE), .IDLE_HOLD(IDLE_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .ack(ack_b), .gate_en(gate_b), .active_cnt(cnt_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, ecount, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ptr[u] = 0;
            for (int i = 0; i < NCH; i++) begin
                m_en[u][i]  = 0;
                m_ack[u][i] = 0;
                m_gt[u][i]  = 0;
                m_dt[u][i]  = -1;
            end
        end
    endtask

    // Enabled channel: ack once WAKE edges have passed since the grant with
    // req held; dropping req starts an idle window of `idle` edges; re-request
    // inside the window resumes ack at once. Free slots go to the first
    // requesting, previously idle channel from the pointer.
    task automatic model_step(input int u, input logic [3:0] r, input int maxa, input int idle);
        int was_en[4];
        int used;
        int id;
        bit done;
        for (int i = 0; i < NCH; i++) was_en[i] = m_en[u][i];
        for (int i = 0; i < NCH; i++) begin
            if (m_en[u][i] != 0) begin
                if (r[i]) begin
                    if (m_dt[u][i] >= 0) begin
                        m_dt[u][i]  = -1;
                        m_ack[u][i] = 1;
                        m_gt[u][i]  = ecount - WAKE;
                    end else begin
                        m_ack[u][i] = (ecount - m_gt[u][i] >= WAKE) ? 1 : 0;
                    end
                end else begin
                    m_ack[u][i] = 0;
                    if (m_dt[u][i] < 0) m_dt[u][i] = ecount;
                    if (ecount - m_dt[u][i] >= idle) begin
                        m_en[u][i] = 0;
                        m_dt[u][i] = -1;
                    end
                end
            end
        end
        used = 0;
        for (int i = 0; i < NCH; i++) used = used + m_en[u][i];
        done = 1'b0;
        if (used < maxa) begin
            for (int k = 0; k < NCH; k++) begin
                id = (m_ptr[u] + k) % NCH;
                if (!done && was_en[id] == 0 && r[id]) begin
                    done         = 1'b1;
                    m_en[u][id]  = 1;
                    m_ack[u][id] = 0;
                    m_gt[u][id]  = ecount;
                    m_dt[u][id]  = -1;
                    m_ptr[u]     = (id + 1) % NCH;
                end
            end
        end
    endtask

    // Model advances on every rising edge using the req sampled there.
    always @(posedge clk) begin
        ecount = ecount + 1;
        if (!rst_n) model_reset();
        else begin
            model_step(0, req_a, MAXA_A, IDLE_A);
            model_step(1, req_b, MAXA_B, IDLE_B);
        end
    end

    task automatic compare_unit(input int u, input logic [3:0] g, input logic [3:0] a,
                                input logic [2:0] c, input int maxa);
        logic [3:0] eg, ea;
        int ec;
        ec = 0;
        for (int i = 0; i < NCH; i++) begin
            eg[i] = (m_en[u][i] != 0);
            ea[i] = (m_ack[u][i] != 0);
            ec    = ec + m_en[u][i];
        end
        check($sformatf("model_gate_en_u%0d", u), int'(g), int'(eg));
        check($sformatf("model_ack_u%0d", u), int'(a), int'(ea));
        check($sformatf("model_active_cnt_u%0d", u), int'(c), ec);
        check($sformatf("active_le_max_u%0d", u), int'(int'(c) <= maxa), 1);
    endtask

    // Compare process: outputs checked on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            compare_unit(0, gate_a, ack_a, cnt_a, MAXA_A);
            compare_unit(1, gate_b, ack_b, cnt_b, MAXA_B);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack_a(input int ch, input int lim, output int ok);
        ok = 0;
        for (int c = 0; c < lim && ok == 0; c++) begin
            tick();
            if (ack_a[ch]) ok = 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog edge=%0d actual=running expected=finished", ecount);
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        int ack_run[4];
        logic [3:0] prev_g;
        checks   = 0;
        failures = 0;
        ecount   = 0;
        cmp_en   = 1'b0;
        model_reset();
        rst_n = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;
        #1;
        check("rst_gate_a", int'(gate_a), 0);
        check("rst_ack_a", int'(ack_a), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_gate_b", int'(gate_b), 0);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_gate", int'(gate_a | gate_b), 0);
        end

        // Round-robin on B: each channel drops req 3 cycles after its ack
        exp_q = {};
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        prev_g = gate_b;
        for (int i = 0; i < NCH; i++) ack_run[i] = 0;
        req_b = 4'b1111;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                if (gate_b[i] && !prev_g[i] && exp_q.size() > 0) begin
                    check("rr_grant_order", i, int'(exp_q.pop_front()));
                end
            end
            prev_g = gate_b;
            for (int i = 0; i < NCH; i++) begin
                ack_run[i] = ack_b[i] ? ack_run[i] + 1 : 0;
                req_b[i]   = (ack_run[i] < 3);
            end
        end
        check("rr_all_grants_seen", exp_q.size(), 0);
        req_b = 4'b0000;
        repeat (4) tick();

        // Budget limit on A
        req_a = 4'b1111;
        tick();
        check("bud_e0_gate", int'(gate_a), 4'b0001);
        tick();
        check("bud_e1_gate", int'(gate_a), 4'b0011);
        check("bud_e1_cnt", int'(cnt_a), 2);
        repeat (8) tick();
        check("bud_e9_ack", int'(ack_a), 4'b0011);
        req_a = 4'b1110;
        tick();
        check("bud_e10_ack", int'(ack_a), 4'b0010);
        check("bud_e10_gate", int'(gate_a), 4'b0011);
        repeat (3) tick();
        check("bud_e13_gate", int'(gate_a), 4'b0011);
        tick();
        check("bud_e14_gate", int'(gate_a), 4'b0110);
        check("bud_e14_cnt", int'(cnt_a), 2);
        req_a = 4'b0000;
        repeat (12) tick();
        check("bud_drain_gate", int'(gate_a), 0);

        // Single request on ch1
        req_a = 4'b0010;
        tick();
        check("one_e0_gate", int'(gate_a), 4'b0010);
        check("one_e0_ack", int'(ack_a), 0);
        check("one_e0_cnt", int'(cnt_a), 1);
        tick();
        check("one_e1_ack", int'(ack_a), 0);
        tick();
        check("one_e2_ack", int'(ack_a), 4'b0010);
        repeat (4) tick();
        req_a = 4'b0000;
        tick();
        check("one_drop_ack", int'(ack_a), 0);
        check("one_drop_gate", int'(gate_a), 4'b0010);
        repeat (3) tick();
        check("one_hold3_gate", int'(gate_a), 4'b0010);
        tick();
        check("one_off_gate", int'(gate_a), 0);
        check("one_off_cnt", int'(cnt_a), 0);

        // Sub-cycle req pulse between edges
        @(negedge clk);
        req_a = 4'b0001;
        #2;
        req_a = 4'b0000;
        tick();
        check("glitch_gate", int'(gate_a), 0);

        // Re-request during HOLD on ch2
        req_a = 4'b0100;
        wait_ack_a(2, 10, ok);
        check("hold_ack_seen", ok, 1);
        repeat (2) tick();
        req_a = 4'b0000;
        tick();
        check("hold_d0_gate", int'(gate_a), 4'b0100);
        check("hold_d0_ack", int'(ack_a), 0);
        tick();
        check("hold_d1_gate", int'(gate_a), 4'b0100);
        req_a = 4'b0100;
        tick();
        check("hold_d2_ack", int'(ack_a), 4'b0100);
        check("hold_d2_gate", int'(gate_a), 4'b0100);
        req_a = 4'b0000;
        repeat (8) tick();

        // Async reset while ch3 is waking
        req_a = 4'b1000;
        tick();
        check("ar_wake_gate", int'(gate_a), 4'b1000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ar_gate", int'(gate_a), 0);
        check("ar_ack", int'(ack_a), 0);
        check("ar_cnt", int'(cnt_a), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_g0_gate", int'(gate_a), 4'b1000);
        check("ar_g0_ack", int'(ack_a), 0);
        tick();
        check("ar_g1_ack", int'(ack_a), 0);
        tick();
        check("ar_g2_ack", int'(ack_a), 4'b1000);
        req_a = 4'b0000;
        repeat (8) tick();

        // Random traffic on both units, with occasional async resets
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) req_a[i] = ~req_a[i];
                if ($urandom_range(0, 3) == 0) req_b[i] = ~req_b[i];
            end
            tick();
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst_gate", int'(gate_a | gate_b), 0);
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        req_a = 4'b0000;
        req_b = 4'b0000;
        repeat (10) tick();
        check("final_idle_gate", int'(gate_a | gate_b), 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
